// File: rtl/clr_28bit_pkg.sv
// Shared widths and types for the 28-bit circular-left-rotate unit.
package clr_pkg;
    localparam int CLR_W  = 28;
    localparam int CLR_SW = 4;

    typedef logic [CLR_W-1:0]  clr_data_t;
    typedef logic [CLR_SW-1:0] clr_amt_t;
endpackage

// File: rtl/clr_28bit_if.sv
// Request/result bundle for the registered rotator.
interface clr_28bit_if;
    import clr_pkg::*;

    logic      in_vld;
    clr_data_t x;
    clr_amt_t  y;
    clr_data_t r;
    logic      out_vld;

    modport master (output in_vld, output x, output y, input r, input out_vld);
    modport slave  (input in_vld, input x, input y, output r, output out_vld);
endinterface

// File: rtl/clr_28bit_core.sv
// Combinational log-structured left rotator: stage gi rotates by 2**gi when y[gi] is set.
module clr_28bit_core
    import clr_pkg::*;
(
    input  clr_data_t x,
    input  clr_amt_t  y,
    output clr_data_t r
);
    clr_data_t stg [0:CLR_SW];

    assign stg[0] = x;

    generate
        for (genvar gi = 0; gi < CLR_SW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stg[gi+1] = y[gi] ? {stg[gi][CLR_W-1-SH:0], stg[gi][CLR_W-1:CLR_W-SH]}
                                     : stg[gi];
        end
    endgenerate

    assign r = stg[CLR_SW];
endmodule

// File: rtl/clr_28bit.sv
// Registered 28-bit rotate: one-cycle latency, r holds its value when no valid input arrives.
module clr_28bit
    import clr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    clr_28bit_if.slave  bus
);
    clr_data_t rot;
    clr_data_t r_q, r_d;
    logic      out_vld_q, out_vld_d;

    clr_28bit_core u_core (
        .x (bus.x),
        .y (bus.y),
        .r (rot)
    );

    always_comb begin
        r_d       = r_q;
        out_vld_d = 1'b0;
        if (bus.in_vld) begin
            r_d       = rot;
            out_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            out_vld_q <= 1'b0;
        end else begin
            r_q       <= r_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign bus.r       = r_q;
    assign bus.out_vld = out_vld_q;
endmodule

// File: tb/tb_clr_28bit.sv
// Self-checking bench for clr_28bit: directed cases plus randomized vectors against a bit-index model.
module tb_clr_28bit;
    import clr_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [27:0] exp_r;
    logic        exp_vld;

    clr_28bit_if bus ();

    clr_28bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result bit i comes from x[(i - y) mod 28].
    function automatic logic [27:0] rot_ref(input logic [27:0] v, input int s);
        logic [27:0] res;
        for (int i = 0; i < 28; i++) begin
            res[i] = v[(i - s + 28) % 28];
        end
        return res;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Apply one input cycle, then compare outputs just after the capturing edge.
    task automatic xfer(input logic vld, input logic [27:0] xv, input logic [3:0] yv, input string tag);
        @(negedge clk);
        bus.in_vld = vld;
        bus.x      = xv;
        bus.y      = yv;
        @(posedge clk);
        #1;
        if (vld) exp_r = rot_ref(xv, int'(yv));
        exp_vld = vld;
        $display("xfer %s vld=%0b x=%h y=%0d -> r=%h out_vld=%0b", tag, vld, xv, yv,
                 bus.r, bus.out_vld);
        check_val({tag, ".r"}, {4'h0, bus.r}, {4'h0, exp_r});
        check_val({tag, ".vld"}, {31'h0, bus.out_vld}, {31'h0, exp_vld});
    endtask

    initial begin
        logic [27:0] rx;
        logic [3:0]  ry;
        logic        rv;

        n_checks   = 0;
        n_errors   = 0;
        exp_r      = '0;
        exp_vld    = 1'b0;
        bus.in_vld = 1'b0;
        bus.x      = '0;
        bus.y      = '0;
        rst        = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset.r", {4'h0, bus.r}, 32'h0);
        check_val("reset.vld", {31'h0, bus.out_vld}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        xfer(1'b1, 28'h8000001, 4'd5, "wrap5");
        check_val("wrap5.const", {4'h0, bus.r}, 32'h0000030);
        xfer(1'b1, 28'hABCDEF1, 4'd0, "ident");
        check_val("ident.const", {4'h0, bus.r}, 32'hABCDEF1);
        xfer(1'b1, 28'h0000001, 4'd15, "y15");
        check_val("y15.const", {4'h0, bus.r}, 32'h0008000);
        xfer(1'b1, 28'h8000000, 4'd1, "msb");
        check_val("msb.const", {4'h0, bus.r}, 32'h0000001);

        for (int s = 0; s < 16; s++) begin
            xfer(1'b1, 28'hFFFFFFF, 4'(s), "ones");
            check_val("ones.const", {4'h0, bus.r}, 32'hFFFFFFF);
        end
        xfer(1'b1, 28'h0000000, 4'd7, "zero");

        xfer(1'b1, 28'h1234567, 4'd4, "hold_a");
        check_val("hold_a.const", {4'h0, bus.r}, 32'h2345671);
        xfer(1'b0, 28'hFFFFFFF, 4'd3, "hold_b");
        check_val("hold_b.const", {4'h0, bus.r}, 32'h2345671);

        // Asynchronous reset between edges while a result is valid.
        xfer(1'b1, 28'h00000F0, 4'd2, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        exp_r   = '0;
        exp_vld = 1'b0;
        $display("async reset asserted mid-cycle -> r=%h out_vld=%0b", bus.r, bus.out_vld);
        check_val("arst.r", {4'h0, bus.r}, 32'h0);
        check_val("arst.vld", {31'h0, bus.out_vld}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        xfer(1'b1, 28'h0000003, 4'd8, "post_rst");
        check_val("post_rst.const", {4'h0, bus.r}, 32'h0000300);

        for (int n = 0; n < 10240; n++) begin
            rx = 28'($urandom);
            ry = (n < 1024) ? 4'(n % 16) : 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 7) != 0);
            xfer(rv, rx, ry, "rand");
            if (rv) check_val("rand.pop", $countones(bus.r), $countones(rx));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/clr_28bit.md
Name: clr_28bit

Overview:
- Registered 28-bit circular-left-rotate (barrel rotator) unit.
- Output is input x rotated left by y bit positions, where y is 0..15; bits leaving the MSB re-enter at the LSB.
- Used as the per-round half-key rotation element in the DES-style key schedule.
- Combinational rotator core followed by one output register stage.

Parameters:
- None. Widths are fixed: data 28 bits, rotate amount 4 bits. Both come from package constants.

Ports:
- clk     input   1    system clock, rising-edge active
- rst     input   1    reset, asynchronous, active-high
- in_vld  input   1    qualifies x/y this cycle
- x       input   28   data to rotate
- y       input   4    unsigned rotate amount, 0..15
- r       output  28   registered rotate result
- out_vld output  1    r holds a result captured from a valid input

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Function: rot(x,y) = (x << y) | (x >> (28 - y)), truncated to 28 bits, with bit i of the result = x[(i - y) mod 28].
- y = 0 gives the identity; y never exceeds 15, so there is no wrap of the rotate amount.
- Core: purely combinational, log-structured, 4 stages (rotate by 1, 2, 4, 8), each selected by y[0], y[1], y[2], y[3].
  - Stage k passes its input unchanged when y[k] = 0.
  - No latches. No dependence on in_vld.
- Output register, on each rising clk:
  - if in_vld = 1: r <= rot(x,y) and out_vld <= 1.
  - if in_vld = 0: r holds its previous value and out_vld <= 0.
- Latency: exactly 1 cycle from a valid x/y to r/out_vld. Throughput: one result per cycle; back-to-back valids are allowed with no stall.
- Reset: while rst = 1, r = 28'h0000000 and out_vld = 0, immediately and independent of clk.
  - Reset asserted mid-stream discards any in-flight result.
  - The first capture after release happens on the first rising clk with rst = 0 and in_vld = 1.
- Inputs with X/Z are not required to propagate any defined value.
- Rotation is bit-exact: the population count of r equals that of x.

Decomposition:
- Package clr_pkg holds:
  - CLR_W = 28 and CLR_SW = 4 (localparams).
  - typedef clr_data_t (logic [CLR_W-1:0]).
  - typedef clr_amt_t (logic [CLR_SW-1:0]).
- Sub-module clr_28bit_core: combinational rotator, ports x, y, r, no clock.
- clr_28bit instantiates clr_28bit_core and adds the output register and valid flag.
- The core is reusable where an unregistered rotate is needed.

Test Plan:
- x=28'h8000001, y=5, in_vld=1 -> one cycle later r=28'h0000030, out_vld=1.
- x=28'hABCDEF1, y=0 -> r=28'hABCDEF1. Then x=28'h0000001, y=15 -> r=28'h0008000. Then x=28'h8000000, y=1 -> r=28'h0000001 (MSB wraps to LSB).
- x=28'hFFFFFFF, y=0..15 sweep -> r=28'hFFFFFFF every cycle. Then x=28'h0000000 -> r=0. Back-to-back valids give a result every cycle.
- in_vld=1 with x=28'h1234567, y=4 -> r=28'h2345671. Then in_vld=0 with x=28'hFFFFFFF -> r holds 28'h2345671, out_vld=0.
- Assert rst asynchronously between clock edges while out_vld=1 -> r=0 and out_vld=0 immediately. After release, the next valid x=28'h0000003, y=8 -> r=28'h0000300.
- Randomized compare against the reference model x[(i-y) mod 28], at least 10k vectors, with y covering all 16 values -> zero mismatches.
